// File: rtl/dot_accum_half_precision.sv
// Streaming FP16 dot-product accumulator: accept -> align -> add/normalize, result via valid/ready.
// Define DOT_ACCUM_RNE_EN for round-to-nearest-even; otherwise results are truncated.
module dot_accum_half_precision #(
   parameter int CNT_W = 8
) (
   input  logic             i_Clk,
   input  logic             i_Reset,
   input  logic [15:0]      i_Product,
   input  logic             i_Exception,
   input  logic             i_Valid,
   input  logic             i_Last,
   output logic             o_Ready,
   output logic [15:0]      o_Sum,
   output logic             o_Exception,
   output logic [CNT_W-1:0] o_Count,
   output logic             o_Valid,
   input  logic             i_Ready
);

   typedef enum logic [1:0] {S_ACCEPT, S_ALIGN, S_NORM, S_OUTPUT} state_t;

   state_t             r_state, w_state_next;
   logic [15:0]        r_term, r_acc;
   logic               r_last, r_exc;
   logic [CNT_W-1:0]   r_count;
   logic [13:0]        r_big_ext, r_small_ext;
   logic [4:0]         r_exp;
   logic               r_sign, r_sub;

   // Align: larger magnitude operand is the reference, smaller is shifted with guard/round/sticky.
   logic        w_term_big;
   logic [15:0] w_big, w_small;
   logic [4:0]  w_shift;
   logic [13:0] w_small_raw, w_small_ext, w_lost_mask;

   always_comb begin
      w_term_big  = r_term[14:0] > r_acc[14:0];
      w_big       = w_term_big ? r_term : r_acc;
      w_small     = w_term_big ? r_acc : r_term;
      w_shift     = w_big[14:10] - w_small[14:10];
      w_small_raw = {1'b1, w_small[9:0], 3'b000};
      w_lost_mask = ~(14'h3FFF << w_shift);
      w_small_ext = 14'd1;
      if (w_shift < 5'd14) begin
         w_small_ext    = w_small_raw >> w_shift;
         w_small_ext[0] = w_small_ext[0] | (|(w_small_raw & w_lost_mask));
      end
   end

   // Add/subtract, normalize, round, range check.
   logic [14:0]       w_sum;
   logic [3:0]        w_lzc;
   logic [13:0]       w_norm;
   logic signed [7:0] w_exp_n, w_exp_r;
   logic              w_round_up;
   logic [11:0]       w_mant_r;
   logic [9:0]        w_frac;
   logic [15:0]       w_result, w_acc_next;
   logic              w_range_exc, w_exc_next;

   always_comb begin
      w_sum = r_sub ? ({1'b0, r_big_ext} - {1'b0, r_small_ext})
                    : ({1'b0, r_big_ext} + {1'b0, r_small_ext});
      w_lzc = 4'd0;
      for (int i = 0; i < 14; i++) begin
         if (w_sum[i]) w_lzc = 4'(13 - i);
      end
      if (w_sum[14]) begin
         w_norm  = {w_sum[14:2], w_sum[1] | w_sum[0]};
         w_exp_n = $signed({3'b000, r_exp}) + 8'sd1;
      end else begin
         w_norm  = w_sum[13:0] << w_lzc;
         w_exp_n = $signed({3'b000, r_exp}) - $signed({4'b0000, w_lzc});
      end
`ifdef DOT_ACCUM_RNE_EN
      w_round_up = w_norm[2] & (w_norm[1] | w_norm[0] | w_norm[3]);
`else
      w_round_up = 1'b0;
`endif
      w_mant_r = {1'b0, w_norm[13:3]} + {11'd0, w_round_up};
      w_frac   = w_mant_r[11] ? w_mant_r[10:1] : w_mant_r[9:0];
      w_exp_r  = w_exp_n + (w_mant_r[11] ? 8'sd1 : 8'sd0);

      w_range_exc = 1'b0;
      if (w_norm == 14'd0) begin
         w_result = 16'h0000;
      end else if (w_exp_r > 8'sd31) begin
         w_result    = {r_sign, 15'h7FFF};
         w_range_exc = 1'b1;
      end else if (w_exp_r < 8'sd0) begin
         w_result    = {r_sign, 15'h0000};
         w_range_exc = 1'b1;
      end else begin
         w_result = {r_sign, w_exp_r[4:0], w_frac};
      end

      // Zero operands bypass the datapath: a zero term is a no-op, a zero accumulator takes the term.
      w_acc_next = w_result;
      w_exc_next = r_exc | w_range_exc;
      if (r_term[14:0] == 15'd0) begin
         w_acc_next = r_acc;
         w_exc_next = r_exc;
      end else if (r_acc[14:0] == 15'd0) begin
         w_acc_next = r_term;
         w_exc_next = r_exc;
      end
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_ACCEPT: if (i_Valid) w_state_next = S_ALIGN;
         S_ALIGN:  w_state_next = S_NORM;
         S_NORM:   w_state_next = r_last ? S_OUTPUT : S_ACCEPT;
         S_OUTPUT: if (i_Ready) w_state_next = S_ACCEPT;
         default:  w_state_next = S_ACCEPT;
      endcase
   end

   always_ff @(posedge i_Clk or posedge i_Reset) begin
      if (i_Reset) begin
         r_state     <= S_ACCEPT;
         r_term      <= '0;
         r_last      <= 1'b0;
         r_acc       <= '0;
         r_exc       <= 1'b0;
         r_count     <= '0;
         r_big_ext   <= '0;
         r_small_ext <= '0;
         r_exp       <= '0;
         r_sign      <= 1'b0;
         r_sub       <= 1'b0;
      end else begin
         r_state <= w_state_next;
         case (r_state)
            S_ACCEPT: if (i_Valid) begin
               r_term <= i_Product;
               r_last <= i_Last;
               r_exc  <= r_exc | i_Exception;
            end
            S_ALIGN: begin
               r_big_ext   <= {1'b1, w_big[9:0], 3'b000};
               r_small_ext <= w_small_ext;
               r_exp       <= w_big[14:10];
               r_sign      <= w_big[15];
               r_sub       <= w_big[15] ^ w_small[15];
            end
            S_NORM: begin
               r_acc   <= w_acc_next;
               r_exc   <= w_exc_next;
               r_count <= (&r_count) ? r_count : r_count + CNT_W'(1);
            end
            S_OUTPUT: if (i_Ready) begin
               r_acc   <= '0;
               r_exc   <= 1'b0;
               r_count <= '0;
            end
            default: ;
         endcase
      end
   end

   assign o_Ready     = (r_state == S_ACCEPT);
   assign o_Valid     = (r_state == S_OUTPUT);
   assign o_Sum       = r_acc;
   assign o_Exception = r_exc;
   assign o_Count     = r_count;

endmodule
